// File: rtl/atomik_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : atomik_cmd_pkg
// Purpose  : Shared types and constants for the ATOMiK UART command initiator.
//            Opcode enum, opcode ASCII bytes, payload/reply lengths and the
//            initiator FSM state encoding.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package atomik_cmd_pkg;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_ACCUM  = 2'd1,
    OP_READ   = 2'd2,
    OP_STATUS = 2'd3
  } cmd_op_e;

  localparam logic [7:0] C_ASCII_LOAD   = 8'h4C;  // 'L'
  localparam logic [7:0] C_ASCII_ACCUM  = 8'h41;  // 'A'
  localparam logic [7:0] C_ASCII_READ   = 8'h52;  // 'R'
  localparam logic [7:0] C_ASCII_STATUS = 8'h53;  // 'S'

  localparam int C_PAYLOAD_BYTES = 8;
  localparam logic [3:0] C_RSP_LEN_READ   = 4'd8;
  localparam logic [3:0] C_RSP_LEN_STATUS = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_OP  = 3'd1,
    ST_SEND_PAY = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic logic [7:0] op_ascii(input cmd_op_e op);
    case (op)
      OP_LOAD:   op_ascii = C_ASCII_LOAD;
      OP_ACCUM:  op_ascii = C_ASCII_ACCUM;
      OP_READ:   op_ascii = C_ASCII_READ;
      default:   op_ascii = C_ASCII_STATUS;
    endcase
  endfunction

  // Number of reply bytes the responder sends for a command.
  function automatic logic [3:0] rsp_len(input cmd_op_e op);
    case (op)
      OP_READ:   rsp_len = C_RSP_LEN_READ;
      OP_STATUS: rsp_len = C_RSP_LEN_STATUS;
      default:   rsp_len = 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/atomik_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : atomik_cmd_initiator
// Purpose  : Host-side initiator for the ATOMiK UART command protocol
//            (L/A/R/S). Accepts one command per handshake, streams opcode and
//            payload bytes MSB-first to a UART transmitter, gathers reply bytes
//            from a UART receiver and returns one response beat.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            cmd_valid/ready/op/payload - command request handshake
//            tx_byte/_valid/_ready     - byte stream to UART TX (valid/ready)
//            rx_byte/_valid            - byte strobe from UART RX (no backpressure)
//            rsp_valid/data/zero/timeout - one-cycle response beat, held after
//            rx_stray                  - pulse: rx byte dropped outside reply wait
//            busy                      - inverse of cmd_ready
// Revision : 1.0 - initial release
// ============================================================================
module atomik_cmd_initiator
  import atomik_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_payload,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_timeout,
  output logic        rx_stray,
  output logic        busy
);

  localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          r_state;
  state_e          w_next_state;
  cmd_op_e         r_op;
  logic [63:0]     r_payload;      // shifts left as bytes go out; top byte is on the wire
  logic [2:0]      r_byte_idx;
  logic [3:0]      r_rx_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [63:0]     r_rsp_data;
  logic            r_rsp_zero;
  logic            r_rsp_timeout;
  logic            r_rx_stray;

  logic            w_rx_last;
  logic            w_expired;
  logic            w_has_payload;

  assign w_rx_last     = (r_rx_cnt + 4'd1) == rsp_len(r_op);
  assign w_expired     = (r_to_cnt == C_TO_LAST);
  assign w_has_payload = (r_op == OP_LOAD) || (r_op == OP_ACCUM);

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign rsp_valid   = (r_state == ST_DONE);
  assign rsp_data    = r_rsp_data;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_timeout = r_rsp_timeout;
  assign rx_stray    = r_rx_stray;

  // Next state and the TX byte offer. tx_byte is a pure function of the
  // registered state/payload, so it cannot change while a byte is stalled.
  always_comb begin
    w_next_state  = r_state;
    tx_byte_valid = 1'b0;
    tx_byte       = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_next_state = ST_SEND_OP;
      end
      ST_SEND_OP: begin
        tx_byte_valid = 1'b1;
        tx_byte       = op_ascii(r_op);
        if (tx_byte_ready) w_next_state = w_has_payload ? ST_SEND_PAY : ST_WAIT_RSP;
      end
      ST_SEND_PAY: begin
        tx_byte_valid = 1'b1;
        tx_byte       = r_payload[63:56];
        if (tx_byte_ready && (r_byte_idx == 3'(C_PAYLOAD_BYTES - 1))) w_next_state = ST_DONE;
      end
      ST_WAIT_RSP: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (rx_byte_valid) begin
          if (w_rx_last) w_next_state = ST_DONE;
        end else if (w_expired) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_LOAD;
      r_payload     <= 64'd0;
      r_byte_idx    <= 3'd0;
      r_rx_cnt      <= 4'd0;
      r_to_cnt      <= '0;
      r_rsp_data    <= 64'd0;
      r_rsp_zero    <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rx_stray    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_rx_stray <= rx_byte_valid && (r_state != ST_WAIT_RSP);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op          <= cmd_op_e'(cmd_op);
            r_payload     <= cmd_payload;
            r_rsp_data    <= 64'd0;
            r_rsp_zero    <= 1'b0;
            r_rsp_timeout <= 1'b0;
          end
        end
        ST_SEND_OP: begin
          if (tx_byte_ready) begin
            r_byte_idx <= 3'd0;
            r_rx_cnt   <= 4'd0;
            r_to_cnt   <= '0;
            r_rsp_data <= 64'd0;
          end
        end
        ST_SEND_PAY: begin
          if (tx_byte_ready) begin
            r_payload  <= {r_payload[55:0], 8'h00};
            r_byte_idx <= r_byte_idx + 3'd1;
          end
        end
        ST_WAIT_RSP: begin
          if (rx_byte_valid) begin
            r_rsp_data <= {r_rsp_data[55:0], rx_byte};
            if (r_op == OP_STATUS) r_rsp_zero <= rx_byte[7];
            r_rx_cnt   <= r_rx_cnt + 4'd1;
            r_to_cnt   <= '0;
          end else if (w_expired) begin
            r_rsp_timeout <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
